// File: rtl/trace_capture_if.sv
// rtl/trace_capture_if.sv - probe, control and readback signals of the trace buffer
interface trace_capture_if #(
  parameter int DATA_W = 57,
  parameter int ADDR_W = 6
);
  logic              trig0_i;
  logic              trig1_i;
  logic [DATA_W-1:0] data_i;
  logic              arm_i;
  logic [1:0]        trig_sel_i;
  logic [ADDR_W-1:0] post_cnt_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [1:0]        state_o;
  logic              done_o;
  logic [ADDR_W:0]   count_o;
  logic [ADDR_W-1:0] trig_pos_o;

  modport master (
    output trig0_i, trig1_i, data_i, arm_i, trig_sel_i, post_cnt_i, rd_addr_i,
    input  rd_data_o, state_o, done_o, count_o, trig_pos_o
  );

  modport slave (
    input  trig0_i, trig1_i, data_i, arm_i, trig_sel_i, post_cnt_i, rd_addr_i,
    output rd_data_o, state_o, done_o, count_o, trig_pos_o
  );
endinterface

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - armed circular trace buffer with edge trigger and post-trigger window
module trace_capture #(
  parameter int DATA_W = 57,
  parameter int ADDR_W = 6
) (
  input logic           clk,
  input logic           rst,
  trace_capture_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state;
  logic              trig0_q, trig1_q;
  logic              rise0, rise1, hit, wr_en;
  logic [ADDR_W-1:0] wr_ptr, post_rem, post_lat, trig_pos, rd_phys;
  logic [ADDR_W:0]   count, count_nxt;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    rise0 = bus.trig0_i & ~trig0_q;
    rise1 = bus.trig1_i & ~trig1_q;
    case (bus.trig_sel_i)
      2'b00:   hit = rise0;
      2'b01:   hit = rise1;
      2'b10:   hit = rise0 | rise1;
      default: hit = rise0 & rise1;
    endcase
    wr_en     = ((state == ARMED) || (state == TRIGGERED)) && !bus.arm_i;
    count_nxt = (count == FULL) ? count : count + (ADDR_W+1)'(1);
    // Oldest sample sits count entries behind the write pointer; a full buffer wraps onto wr_ptr.
    rd_phys   = wr_ptr - count[ADDR_W-1:0] + bus.rd_addr_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig0_q <= 1'b0;
      trig1_q <= 1'b0;
    end else begin
      trig0_q <= bus.trig0_i;
      trig1_q <= bus.trig1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_phys];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      post_rem <= '0;
      post_lat <= '0;
      trig_pos <= '0;
      done     <= 1'b0;
    end else if (bus.arm_i) begin
      state    <= ARMED;
      wr_ptr   <= '0;
      count    <= '0;
      trig_pos <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          count  <= count_nxt;
          if (hit) begin
            post_rem <= bus.post_cnt_i;
            post_lat <= bus.post_cnt_i;
            if (bus.post_cnt_i == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              trig_pos <= count_nxt[ADDR_W-1:0] - ADDR_W'(1);
            end else begin
              state <= TRIGGERED;
            end
          end
        end
        TRIGGERED: begin
          wr_ptr   <= wr_ptr + ADDR_W'(1);
          count    <= count_nxt;
          post_rem <= post_rem - ADDR_W'(1);
          if (post_rem == ADDR_W'(1)) begin
            state    <= DONE;
            done     <= 1'b1;
            trig_pos <= count_nxt[ADDR_W-1:0] - ADDR_W'(1) - post_lat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_data_o  = rd_data;
  assign bus.state_o    = state;
  assign bus.done_o     = done;
  assign bus.count_o    = count;
  assign bus.trig_pos_o = trig_pos;
endmodule

// File: doc/trace_capture.md
# trace_capture

On-chip trace buffer for CPU debug, fed by the same probe nets used for JTAG analysis: bus control strobe (`trig0_i`), register-file write enable (`trig1_i`) and a packed data word of register-file contents, source-register index, forwarded operand and LEDs (`data_i`). Once armed it records `data_i` every clock into a circular RAM. It detects a selectable trigger edge, records a programmable number of post-trigger samples, then freezes so the CPU bus or the debugger can read the window back.

## Interface
- `DATA_W`, 57, probe word width
- `ADDR_W`, 6, buffer address width; depth `DEPTH = 2**ADDR_W`
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `trig0_i`  in  1  trigger source 0 (bus ctrl)
- `trig1_i`  in  1  trigger source 1 (register write enable)
- `data_i`  in  DATA_W  probe word sampled each armed cycle
- `arm_i`  in  1  single-cycle pulse that clears and (re)starts capture
- `trig_sel_i`  in  2  00 = trig0 rise, 01 = trig1 rise, 10 = either rise, 11 = both rise in same cycle
- `post_cnt_i`  in  ADDR_W  samples to record after the trigger sample
- `rd_addr_i`  in  ADDR_W  read index relative to oldest stored sample
- `rd_data_o`  out  DATA_W  registered read data
- `state_o`  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
- `done_o`  out  1  high while in DONE
- `count_o`  out  ADDR_W+1  valid samples stored, saturates at DEPTH
- `trig_pos_o`  out  ADDR_W  index of trigger sample relative to oldest; valid in DONE

## Operation
- Edge detect: `trig0_q`/`trig1_q` register the inputs every cycle in every state. `rise_n = trig_n_i & ~trig_n_q`. Trigger hit is selected by `trig_sel_i` from these rises, evaluated combinationally in the current cycle.
- Storage: single-port-write / single-port-read RAM of DEPTH x DATA_W. `wr_ptr` is ADDR_W wide and wraps modulo DEPTH.
- The oldest sample is at `wr_ptr - count_o` (mod DEPTH). Physical read address = oldest + `rd_addr_i` (mod DEPTH).
- FSM:
  - IDLE: no writes. On `arm_i` -> ARMED; clear `wr_ptr`, `count_o`, `trig_pos_o`, `done_o`.
  - ARMED: write `data_i` at `wr_ptr`, `wr_ptr++`, `count_o` increments and saturates at DEPTH. If hit in the same cycle: latch `post_cnt_i` into `post_rem`; if `post_rem == 0` -> DONE, else -> TRIGGERED.
  - TRIGGERED: write as in ARMED, `post_rem--`. When the write with `post_rem == 1` occurs -> DONE. Further hits are ignored.
  - DONE: no writes. Set `done_o`. Set `trig_pos_o = count_o - 1 - post_cnt_latched`. Hold until `arm_i`.
- `arm_i` in any state, including ARMED and TRIGGERED, restarts as from IDLE. No write occurs in the arm cycle.
- `trig_sel_i` and `post_cnt_i` must be stable from arm until the trigger. Only the value at the trigger cycle matters.
- Reads are legal in any state. Content is defined only for `rd_addr_i < count_o` in DONE; otherwise stale RAM data is returned.

## Timing
- Reset values: `state_o = 0`, `done_o = 0`, `count_o = 0`, `trig_pos_o = 0`, `rd_data_o = 0`, `wr_ptr = 0`, `trig0_q = trig1_q = 0`. RAM contents are not reset.
- `arm_i` high in cycle N: `state_o = 1` from N+1, and the first sample is written at N+1.
- Trigger hit in cycle T (sample T is written): DONE is visible at T+1+post. The last sample written is T+post.
- `done_o`, `count_o` and `trig_pos_o` change on the clock edge entering DONE.
- Read latency is 1 cycle: `rd_data_o` in cycle k+1 reflects `rd_addr_i` from cycle k.
- Asynchronous `rst` mid-capture returns all outputs to reset values immediately. Capture resumes only after a new `arm_i`.

## Test plan
- Reset: assert `rst` while TRIGGERED -> `state_o = 0`, `done_o = 0`, `count_o = 0`, `rd_data_o = 0` without a clock edge.
- Basic capture: arm at cycle 0, `data_i = cycle number`, `trig_sel = 01`, `post_cnt = 3`, `trig1_i` rises at cycle 6 -> DONE at cycle 10, `count_o = 9`, `trig_pos_o = 5`, `rd_addr 0` reads 1, `rd_addr 5` reads 6, `rd_addr 8` reads 9.
- Wrap: `ADDR_W = 6`, trigger after 100 armed cycles, `post_cnt = 10` -> `count_o = 64`, `trig_pos_o = 53`. `rd_addr 0` reads the sample written 63 cycles before the last one; `rd_addr 63` reads the last sample.
- Edge only: `trig0_i` held high from before arm, `trig_sel = 00` -> stays ARMED. Drop `trig0_i` then raise it again -> trigger on the rise cycle.
- AND mode: `trig_sel = 11`, `trig0_i` rises at cycle 4 and `trig1_i` at cycle 5 -> no trigger. Both rise at cycle 9 -> trigger; with `post_cnt = 0`, DONE at cycle 10.
- Re-arm while TRIGGERED -> `state_o = 1` and `count_o = 0` next cycle, `done_o` stays 0, and the earlier trigger is discarded.
